// File: rtl/tree_walker_if.sv
// tree_walker_if: start/feature-write/result handshake and tree ROM port of one tree_walker.
// The master side is the host plus the tree ROM; the slave side is the walker.
interface tree_walker_if #(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int FEAT_W     = 64
);
    logic                  start;
    logic                  feat_we;
    logic [3:0]            feat_waddr;
    logic [FEAT_W-1:0]     feat_wdata;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NODE_WIDTH-1:0] node_data;
    logic                  busy;
    logic                  done;
    logic [3:0]            class_out;
    logic                  err;
    logic [5:0]            depth_out;

    modport master (
        output start, feat_we, feat_waddr, feat_wdata, node_data,
        input  addr, busy, done, class_out, err, depth_out
    );

    modport slave (
        input  start, feat_we, feat_waddr, feat_wdata, node_data,
        output addr, busy, done, class_out, err, depth_out
    );
endinterface

// File: rtl/tree_walker.sv
// tree_walker: walks one decision tree held in a registered tree ROM and reports the leaf class.
// Optional TREE_NODE_ID_CHECK_EN: each node's node_id must match the address it was fetched from.
module tree_walker #(
    parameter int         NODE_WIDTH   = 120,
    parameter int         ADDR_WIDTH   = 10,
    parameter int         NUM_FEATURES = 16,
    parameter int         FEAT_W       = 64,
    parameter int         MAX_DEPTH    = 32,
    parameter logic [3:0] LEAF_CODE    = 4'h3
) (
    input logic          clk,
    input logic          rst_n,
    tree_walker_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [5:0]        step_r;
    logic [FEAT_W-1:0] feat_r [NUM_FEATURES];

    logic [11:0]       node_id_s;
    logic [3:0]        node_feat_s;
    logic [FEAT_W-1:0] node_thr_s;
    logic [11:0]       left_s;
    logic [11:0]       right_s;
    logic [11:0]       child_s;
    logic [3:0]        node_class_s;
    logic [FEAT_W-1:0] feat_val_s;
    logic [5:0]        step_nxt_s;
    logic              is_leaf_s;
    logic              feat_bad_s;
    logic              depth_hit_s;
    logic              id_bad_s;
    logic              end_err_s;
    logic              finish_s;
    logic              unused_s;

    // IEEE-754 a <= b on raw bit patterns; NaNs are not expected and -0 equals +0.
    function automatic logic dbl_le(input logic [FEAT_W-1:0] a, input logic [FEAT_W-1:0] b);
        logic le;
        case ({a[FEAT_W-1], b[FEAT_W-1]})
            2'b00:   le = (a <= b);
            2'b11:   le = (a >= b);
            2'b10:   le = 1'b1;
            2'b01:   le = (a[FEAT_W-2:0] == {(FEAT_W-1){1'b0}}) && (b[FEAT_W-2:0] == {(FEAT_W-1){1'b0}});
            default: le = 1'b0;
        endcase
        return le;
    endfunction

    assign node_id_s    = bus.node_data[107:96];
    assign node_feat_s  = bus.node_data[95:92];
    assign node_thr_s   = bus.node_data[91:28];
    assign left_s       = bus.node_data[27:16];
    assign right_s      = bus.node_data[15:4];
    assign node_class_s = bus.node_data[3:0];
    assign unused_s     = ^{bus.node_data[NODE_WIDTH-1:108], node_id_s, child_s};

    // Decode the current node: feature select, branch direction and walk-ending conditions
    always_comb begin
        feat_val_s = {FEAT_W{1'b0}};
        for (int i = 0; i < NUM_FEATURES; i++) begin
            feat_val_s = (node_feat_s == 4'(i)) ? feat_r[i] : feat_val_s;
        end
        step_nxt_s  = step_r + 6'd1;
        is_leaf_s   = (node_feat_s == LEAF_CODE);
        feat_bad_s  = ({1'b0, node_feat_s} >= 5'(NUM_FEATURES));
        depth_hit_s = (step_nxt_s >= 6'(MAX_DEPTH));
        child_s     = dbl_le(feat_val_s, node_thr_s) ? left_s : right_s;
`ifdef TREE_NODE_ID_CHECK_EN
        id_bad_s    = (node_id_s[ADDR_WIDTH-1:0] != bus.addr);
`else
        id_bad_s    = 1'b0;
`endif
        end_err_s   = id_bad_s || (!is_leaf_s && (feat_bad_s || depth_hit_s));
        finish_s    = end_err_s || is_leaf_s;
    end

    // Feature registers accept host writes only while no walk is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                feat_r[i] <= {FEAT_W{1'b0}};
            end
        end else if (bus.feat_we && !bus.busy) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                if (bus.feat_waddr == 4'(i)) begin
                    feat_r[i] <= bus.feat_wdata;
                end
            end
        end
    end

    // Walk FSM: FETCH gives the ROM its read cycle, EVAL consumes node_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            step_r        <= 6'd0;
            bus.addr      <= {ADDR_WIDTH{1'b0}};
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.class_out <= 4'd0;
            bus.err       <= 1'b0;
            bus.depth_out <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.addr <= {ADDR_WIDTH{1'b0}};
                        step_r   <= 6'd0;
                        bus.busy <= 1'b1;
                        state_r  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_EVAL;
                end
                ST_EVAL: begin
                    step_r <= step_nxt_s;
                    if (finish_s) begin
                        bus.done      <= 1'b1;
                        bus.err       <= end_err_s;
                        bus.class_out <= end_err_s ? 4'd0 : node_class_s;
                        bus.depth_out <= step_nxt_s;
                        state_r       <= ST_DONE;
                    end else begin
                        bus.addr <= child_s[ADDR_WIDTH-1:0];
                        state_r  <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
